// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial pattern scanner: FSM state encoding and
// the power-up pattern/length loaded on reset.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  localparam logic [5:0] SEQ_DEFAULT_PAT = 6'b111001;
  localparam int         SEQ_DEFAULT_LEN = 6;

endpackage

// File: rtl/seq_match_core.sv
// Serial Moore matcher: bit history, fill counter, length-masked compare and
// registered match pulse. SEQ_SCAN_OVERLAP_EN keeps fill on a match.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 6,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             match
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
  logic             match_q, match_d;
  logic [PAT_W-1:0] bit_ok;

  assign hist_shift = {hist_q[PAT_W-2:0], bit_in};
  // Fill saturates at PAT_W; it only needs to prove "at least len bits seen".
  assign fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);

  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
    assign bit_ok[gi] = (LEN_W'(gi) >= len) || (hist_shift[gi] == pattern[gi]);
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d  = hist_shift;
      match_d = (len != '0) && (fill_inc >= len) && (&bit_ok);
`ifdef SEQ_SCAN_OVERLAP_EN
      fill_d  = fill_inc;
`else
      fill_d  = match_d ? '0 : fill_inc;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller: accepts words, shifts them MSB-first into
// seq_match_core and counts matches. SEQ_SCAN_OVERLAP_EN selects overlapping matches.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         bit_out,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_clear, core_bit_valid;

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    last_d         = last_q;
    idx_d          = idx_q;
    pat_d          = pat_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    core_clear     = 1'b0;
    core_bit_valid = 1'b0;
    in_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    bit_out        = 1'b0;

    if (match && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        in_ready = ~cfg_we;
        // Configuration takes priority over an offered word in the same cycle.
        if (cfg_we) begin
          pat_d      = cfg_pattern;
          len_d      = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
          cnt_d      = '0;
          core_clear = 1'b1;
        end else if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = IDX_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy           = 1'b1;
        bit_out        = word_q[DATA_W-1];
        core_bit_valid = 1'b1;
        word_d         = word_q << 1;
        if (idx_q == '0) state_d = last_q ? DONE : IDLE;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        core_clear = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      pat_q   <= PAT_W'(SEQ_DEFAULT_PAT);
      len_q   <= LEN_W'(SEQ_DEFAULT_LEN);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (core_bit_valid),
    .bit_in    (bit_out),
    .clear     (core_clear),
    .pattern   (pat_q),
    .len       (len_q),
    .match     (match)
  );

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus random words
// checked cycle by cycle against a queue-based reference model.
module tb_seq_scan_ctrl;

  localparam int PAT_W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_pattern = '0;
  logic [2:0]  cfg_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;

  logic        in_ready, bit_out, match, busy, done;
  logic [7:0]  match_cnt;
  logic        in_ready2, bit_out2, match2, busy2, done2;
  logic [1:0]  match_cnt2;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [5:0] mpat;
  int         mlen;
  bit         mq[$];
  int         mcnt, mcnt2;
  int         last_nm;
  bit         saw_done;
  logic [5:0] rp;
  logic [2:0] rl;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.DATA_W(16), .PAT_W(6), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .bit_out(bit_out), .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  seq_scan_ctrl #(.DATA_W(16), .PAT_W(6), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .bit_out(bit_out2), .match(match2), .match_cnt(match_cnt2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpat = 6'b111001;
    mlen = 6;
    mq.delete();
    mcnt = 0;
    mcnt2 = 0;
  endtask

  task automatic model_bit(input bit b, output bit hit);
    hit = 1'b0;
    mq.push_back(b);
    if (mq.size() > PAT_W) void'(mq.pop_front());
    if (mlen > 0 && mq.size() >= mlen) begin
      hit = 1'b1;
      for (int i = 0; i < mlen; i++)
        if (mq[mq.size() - mlen + i] != mpat[mlen - 1 - i]) hit = 1'b0;
    end
    if (hit) begin
      if (mcnt < 255) mcnt++;
      if (mcnt2 < 3) mcnt2++;
`ifndef SEQ_SCAN_OVERLAP_EN
      mq.delete();
`endif
    end
  endtask

  // cfg_we is raised together with in_valid: the word must not be taken.
  task automatic do_cfg(input logic [5:0] p, input logic [2:0] l);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l;
    in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'b1;
    @(negedge clk);
    chk("cfg_ready_low", in_ready, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("cfg_no_accept", busy, 0);
    chk("cfg_cnt_clear", match_cnt, 0);
    mpat = p;
    mlen = (l > 3'd6) ? 6 : int'(l);
    mq.delete();
    mcnt = 0;
    mcnt2 = 0;
    $display("cfg pattern=%b len=%0d", p, l);
  endtask

  task automatic send_word(input logic [15:0] data, input bit last, input bit poke);
    bit exp[16];
    int nm;
    nm = 0;
    for (int k = 0; k < 16; k++) begin
      model_bit(data[15-k], exp[k]);
      nm += int'(exp[k]);
    end
    if (last) mq.delete();
    @(posedge clk); #1;
    in_data = data; in_last = last; in_valid = 1'b1;
    if (poke) begin cfg_pattern = 6'b000001; cfg_len = 3'd1; end
    @(negedge clk);
    chk("accept_ready", in_ready, 1);
    chk("idle_bit_out", bit_out, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("bit_out", bit_out, data[15-k]);
      chk("shift_match", match, (k == 0) ? 1'b0 : exp[k-1]);
      chk("shift_busy", busy, 1);
      chk("shift_ready", in_ready, 0);
      if (poke) cfg_we = (k == 3);
    end
    @(negedge clk);
    chk("last_bit_match", match, exp[15]);
    chk("done_pulse", done, last);
    chk("tail_busy", busy, last);
    chk("tail_ready", in_ready, !last);
    if (last) begin
      @(negedge clk);
      chk("after_done", done, 0);
      chk("after_done_ready", in_ready, 1);
    end
    @(negedge clk);
    chk("idle_match", match, 0);
    chk("idle_bit_out2", bit_out, 0);
    chk("cnt", match_cnt, mcnt);
    chk("cnt_sat2", match_cnt2, mcnt2);
    last_nm = nm;
    $display("word %04h last=%0d matches=%0d cnt=%0d", data, last, nm, match_cnt);
  endtask

  initial begin
    // 1: reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    // 2: default pattern 111001
    send_word(16'hE400, 1'b1, 1'b0);
    chk("t2_matches", last_nm, 1);
    chk("t2_cnt", match_cnt, 1);

    // 3: pattern 101
    do_cfg(6'b000101, 3'd3);
    send_word(16'hA800, 1'b1, 1'b0);
`ifdef SEQ_SCAN_OVERLAP_EN
    chk("t3_cnt", match_cnt, 2);
`else
    chk("t3_cnt", match_cnt, 1);
`endif

    // 4: match spanning a word boundary; cfg_we poked mid-shift must be ignored
    do_cfg(6'b111001, 3'd6);
    send_word(16'h0007, 1'b0, 1'b0);
    send_word(16'h2000, 1'b1, 1'b1);
    chk("t4_cnt", match_cnt, 1);

    // 5: single-bit pattern, 2-bit counter saturates
    do_cfg(6'b000001, 3'd1);
    send_word(16'hFFFF, 1'b1, 1'b0);
    chk("t5_matches", last_nm, 16);
    chk("t5_cnt8", match_cnt, 16);
    chk("t5_cnt2", match_cnt2, 3);

    // random words; first two configs cover len=0 and len>PAT_W
    for (int w = 0; w < 36; w++) begin
      if (w % 6 == 0) begin
        rp = 6'($urandom);
        if (w == 0)      rl = 3'd0;
        else if (w == 6) rl = 3'd7;
        else             rl = 3'($urandom_range(1, 4));
        do_cfg(rp, rl);
      end
      send_word(16'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    // 6: reset in the middle of a shift drops the word
    do_cfg(6'b000001, 3'd1);
    @(posedge clk); #1;
    in_data = 16'hFFFF; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_match", match, 0);
    chk("mid_rst_cnt", match_cnt, 0);
    chk("mid_rst_bit_out", bit_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || match || busy) saw_done = 1'b1;
    end
    chk("no_done_after_rst", saw_done, 0);
    chk("post_rst_cnt", match_cnt, 0);
    send_word(16'hE400, 1'b1, 1'b0);
    chk("post_rst_default", last_nm, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
